// File: rtl/fetch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fetch_unit : credit-limited instruction fetch with redirect squash queue  |
// | Revision   : 1.0                                                          |
// +--------------------------------------------------------------------------+
module fetch_unit #(
    parameter int               XLEN         = 32,
    parameter int               DEPTH        = 4,
    parameter logic [XLEN-1:0]  RESET_VECTOR = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_inst,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_pc_plus4
);

    localparam int              AW        = $clog2(DEPTH);
    localparam int              CW        = AW + 1;
    localparam int              DEPTH_I   = DEPTH;
    localparam logic [CW:0]     OCC_LIMIT = DEPTH_I[CW:0];
    localparam logic [XLEN-1:0] PC_STEP   = {{(XLEN-3){1'b0}}, 3'b100};

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] rsp_pc;
    logic [XLEN-1:0] pc_mem   [DEPTH];
    logic [XLEN-1:0] pcp4_mem [DEPTH];
    logic [XLEN-1:0] inst_mem [DEPTH];
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic [CW-1:0]   count;
    logic [CW-1:0]   inflight;
    logic [CW-1:0]   discard;

    logic            req_fire;
    logic            rsp_ok;
    logic            push;
    logic            pop;
    logic [CW-1:0]   fire_inc;
    logic [CW-1:0]   rsp_dec;
    logic [CW-1:0]   push_inc;
    logic [CW-1:0]   pop_dec;
    logic [XLEN-1:0] target_pc;
    logic [XLEN-1:0] rsp_pc_next;
    logic            unused_redirect_lo;

    assign unused_redirect_lo = ^redirect_pc[1:0];
    assign target_pc          = {redirect_pc[XLEN-1:2], 2'b00};
    assign rsp_pc_next        = rsp_pc + PC_STEP;

    // Credit rule: queued plus outstanding never exceeds the queue depth.
    assign imem_req_valid = rst && !redirect_valid &&
                            (({1'b0, count} + {1'b0, inflight}) < OCC_LIMIT);
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // Responses arriving with nothing outstanding are stray and ignored.
    assign rsp_ok = imem_rsp_valid && (inflight != '0);
    assign push   = rsp_ok && (discard == '0) && !redirect_valid;

    assign out_valid    = (count != '0) && !redirect_valid;
    assign pop          = out_valid && out_ready;
    assign out_inst     = inst_mem[rd_ptr];
    assign out_pc       = pc_mem[rd_ptr];
    assign out_pc_plus4 = pcp4_mem[rd_ptr];

    assign fire_inc = {{(CW-1){1'b0}}, req_fire};
    assign rsp_dec  = {{(CW-1){1'b0}}, rsp_ok};
    assign push_inc = {{(CW-1){1'b0}}, push};
    assign pop_dec  = {{(CW-1){1'b0}}, pop};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc <= RESET_VECTOR;
            rsp_pc   <= RESET_VECTOR;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            inflight <= '0;
            discard  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem[i]   <= '0;
                pcp4_mem[i] <= '0;
                inst_mem[i] <= '0;
            end
        end else if (redirect_valid) begin
            // Everything still outstanding belongs to the old path.
            fetch_pc <= target_pc;
            rsp_pc   <= target_pc;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            inflight <= inflight - rsp_dec;
            discard  <= inflight - rsp_dec;
        end else begin
            if (req_fire) begin
                fetch_pc <= fetch_pc + PC_STEP;
            end
            inflight <= inflight + fire_inc - rsp_dec;
            if (rsp_ok && (discard != '0)) begin
                discard <= discard - 1'b1;
            end
            if (push) begin
                pc_mem[wr_ptr]   <= rsp_pc;
                pcp4_mem[wr_ptr] <= rsp_pc_next;
                inst_mem[wr_ptr] <= imem_rsp_data;
                wr_ptr           <= wr_ptr + 1'b1;
                rsp_pc           <= rsp_pc_next;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + push_inc - pop_dec;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_fetch_unit : scoreboard bench with latency-programmable memory model   |
// | Revision      : 1.0                                                       |
// +--------------------------------------------------------------------------+
module tb_fetch_unit;

    localparam int          DEPTH = 4;
    localparam logic [31:0] RV    = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic [31:0] out_pc_plus4;

    fetch_unit #(.XLEN(32), .DEPTH(DEPTH), .RESET_VECTOR(RV)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_inst(out_inst), .out_pc(out_pc), .out_pc_plus4(out_pc_plus4)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          mem_lat = 1;
    int          disc = 0;
    logic [31:0] model_pc = RV;
    logic [31:0] mem_addr_q[$];
    int          mem_due_q[$];
    logic [31:0] exp_q[$];

    int          fires, pops, first_out;
    logic [31:0] first_pop_pc;
    logic        saw_wrap;
    logic        last_req_valid;
    logic [31:0] last_req_addr;
    logic        red_rsp;
    int          red_inflight;
    int          red_mcount;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    function automatic logic [31:0] b2w(input logic b);
        return b ? 32'd1 : 32'd0;
    endfunction

    // One clock cycle, entered and left just after a falling edge.
    task automatic tick();
        int          mcount;
        logic [31:0] epc;
        logic [31:0] e4;
        if (mem_addr_q.size() > 0 && mem_due_q[0] <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = inst_of(mem_addr_q[0]);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'hDEAD_BEEF;
        end
        #1;
        mcount = exp_q.size() - (mem_addr_q.size() - disc);
        check("req_valid", b2w(imem_req_valid),
              b2w(!redirect_valid && (exp_q.size() + disc < DEPTH)));
        check("out_valid", b2w(out_valid), b2w(!redirect_valid && mcount > 0));
        if (imem_req_valid) check("req_addr", imem_req_addr, model_pc);
        last_req_valid = imem_req_valid;
        last_req_addr  = imem_req_addr;
        if (redirect_valid) begin
            red_rsp      = imem_rsp_valid;
            red_inflight = mem_addr_q.size();
            red_mcount   = mcount;
            exp_q.delete();
            disc     = mem_addr_q.size() - (imem_rsp_valid ? 1 : 0);
            model_pc = {redirect_pc[31:2], 2'b00};
        end else begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("pop_empty", exp_q.size(), 0);
                end else begin
                    epc = exp_q.pop_front();
                    e4  = epc + 32'd4;
                    check("out_pc", out_pc, epc);
                    check("out_inst", out_inst, inst_of(epc));
                    check("out_pc_plus4", out_pc_plus4, e4);
                    if (pops == 0) first_pop_pc = out_pc;
                    if (out_pc == 32'hFFFF_FFFC && out_pc_plus4 == 32'h0) saw_wrap = 1'b1;
                end
                pops++;
            end
            if (imem_req_valid && imem_req_ready) begin
                exp_q.push_back(model_pc);
                model_pc = model_pc + 32'd4;
            end
        end
        if (imem_req_valid && imem_req_ready) begin
            mem_addr_q.push_back(imem_req_addr);
            mem_due_q.push_back(cyc + mem_lat);
            fires++;
        end
        if (imem_rsp_valid) begin
            void'(mem_addr_q.pop_front());
            void'(mem_due_q.pop_front());
            if (!redirect_valid && disc > 0) disc--;
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic clear_model();
        mem_addr_q.delete();
        mem_due_q.delete();
        exp_q.delete();
        disc     = 0;
        model_pc = RV;
        fires    = 0;
        pops     = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_out_valid"}, b2w(out_valid), 32'd0);
        check({tag, "_req_valid"}, b2w(imem_req_valid), 32'd0);
        check({tag, "_req_addr"}, imem_req_addr, RV);
        check({tag, "_out_inst"}, out_inst, 32'd0);
        check({tag, "_out_pc"}, out_pc, 32'd0);
        check({tag, "_out_pc_plus4"}, out_pc_plus4, 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        imem_rsp_valid = 1'b0;
        redirect_valid = 1'b0;
        clear_model();
        #1;
        check_reset_outputs("rst");
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        rst            = 1'b0;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        out_ready      = 1'b1;
        saw_wrap       = 1'b0;
        first_out      = 0;

        // Streaming at L=1: first output three cycles after release.
        mem_lat = 1;
        do_reset();
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 1) check("first_cycle_req", b2w(last_req_valid), 32'd1);
            if (pops > 0 && first_out == 0) first_out = i;
        end
        check("first_out_cycle", first_out, 32'd3);
        check("stream_pops", pops, 32'd18);
        check("stream_first_pc", first_pop_pc, RV);

        // Backpressure: exactly DEPTH requests, then drain in order.
        do_reset();
        out_ready = 1'b0;
        repeat (10) tick();
        check("bp_fires", fires, DEPTH);
        check("bp_count", 32'(dut.count), DEPTH);
        out_ready = 1'b1;
        repeat (8) tick();
        check("bp_first_pc", first_pop_pc, RV);

        // Redirect with three requests in flight and no response this cycle.
        mem_lat = 4;
        do_reset();
        repeat (3) tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_2002;
        tick();
        redirect_valid = 1'b0;
        check("sq_discard", 32'(dut.discard), 32'd3);
        pops = 0;
        tick();
        check("sq_req_valid", b2w(last_req_valid), 32'd1);
        check("sq_req_addr", last_req_addr, 32'h0000_2000);
        repeat (20) tick();
        check("sq_first_pc", first_pop_pc, 32'h0000_2000);

        // Redirect coincident with a response and a would-be pop.
        mem_lat = 2;
        do_reset();
        repeat (6) tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_3000;
        tick();
        redirect_valid = 1'b0;
        check("co_rsp_seen", b2w(red_rsp), 32'd1);
        check("co_head_ready", b2w(red_mcount > 0), 32'd1);
        check("co_count", 32'(dut.count), 32'd0);
        check("co_discard", 32'(dut.discard), red_inflight - 1);
        pops = 0;
        repeat (12) tick();
        check("co_first_pc", first_pop_pc, 32'h0000_3000);

        // Address wrap at the top of the address space.
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFB;
        tick();
        redirect_valid = 1'b0;
        pops = 0;
        repeat (12) tick();
        check("wrap_first_pc", first_pop_pc, 32'hFFFF_FFF8);
        check("wrap_seen", b2w(saw_wrap), 32'd1);

        // Random traffic with occasional redirects.
        for (int blk = 0; blk < 6; blk++) begin
            mem_lat = $urandom_range(1, 3);
            for (int i = 0; i < 50; i++) begin
                imem_req_ready = ($urandom_range(0, 3) != 0);
                out_ready      = ($urandom_range(0, 4) > 1);
                redirect_valid = ($urandom_range(0, 31) == 0);
                redirect_pc    = $urandom;
                tick();
            end
        end
        redirect_valid = 1'b0;
        imem_req_ready = 1'b1;
        out_ready      = 1'b1;
        repeat (10) tick();

        // Asynchronous reset with a full queue, between clock edges.
        mem_lat = 1;
        do_reset();
        out_ready = 1'b0;
        repeat (8) tick();
        check("ar_full", 32'(dut.count), DEPTH);
        #2;
        rst = 1'b0;
        imem_rsp_valid = 1'b0;
        #1;
        check_reset_outputs("async");
        clear_model();
        repeat (2) @(negedge clk);
        rst       = 1'b1;
        out_ready = 1'b1;
        tick();
        check("ar_restart_valid", b2w(last_req_valid), 32'd1);
        check("ar_restart_addr", last_req_addr, RV);
        repeat (10) tick();
        check("ar_first_pc", first_pop_pc, RV);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
